vga_sync_gen: RTL

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/sync_delay_line.sv | 35 +++
 rtl/vga_sync_gen.sv | 103 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and small helpers for the sync generator.
package vga_timing_pkg;

  localparam int unsigned CntW = 10;
  typedef logic [CntW-1:0] cnt_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
  } sync_t;

  localparam int unsigned HActive    = 640;
  localparam int unsigned HFp        = 16;
  localparam int unsigned HSync      = 96;
  localparam int unsigned HBp        = 48;
  localparam int unsigned HTotal     = HActive + HFp + HSync + HBp;
  localparam int unsigned HSyncStart = HActive + HFp;
  localparam int unsigned HSyncEnd   = HSyncStart + HSync - 1;

  localparam int unsigned VActive    = 480;
  localparam int unsigned VFp        = 10;
  localparam int unsigned VSync      = 2;
  localparam int unsigned VBp        = 33;
  localparam int unsigned VTotal     = VActive + VFp + VSync + VBp;
  localparam int unsigned VSyncStart = VActive + VFp;
  localparam int unsigned VSyncEnd   = VSyncStart + VSync - 1;

  // Inclusive window test used for both sync pulses.
  function automatic logic in_window(input cnt_t v, input cnt_t lo, input cnt_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Enable-qualified shift register that delays the {hsync, vsync} pair; resets to 1.
module sync_delay_line
  import vga_timing_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       en,
  input  logic [1:0] sync_in,
  output logic [1:0] sync_out
);

  if (Depth == 0) begin : g_bypass
    assign sync_out = sync_in;
  end else begin : g_shift
    logic [1:0] stage_q [Depth];

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        for (int unsigned i = 0; i < Depth; i++) begin
          stage_q[i] <= 2'b11;
        end
      end else if (en) begin
        stage_q[0] <= sync_in;
        for (int unsigned i = 1; i < Depth; i++) begin
          stage_q[i] <= stage_q[i-1];
        end
      end
    end

    assign sync_out = stage_q[Depth-1];
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters, blanking flags, delayed syncs, frame pulse.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = HActive,
  parameter int unsigned H_FP       = HFp,
  parameter int unsigned H_SYNC     = HSync,
  parameter int unsigned H_BP       = HBp,
  parameter int unsigned V_ACTIVE   = VActive,
  parameter int unsigned V_FP       = VFp,
  parameter int unsigned V_SYNC     = VSync,
  parameter int unsigned V_BP       = VBp,
  parameter int unsigned SYNC_DELAY = 1
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            pix_en,
  output logic [CntW-1:0] col,
  output logic [CntW-1:0] row,
  output logic            hnotactive,
  output logic            vnotactive,
  output logic            hsync,
  output logic            vsync,
  output logic            frame_start
);

  localparam cnt_t HLast   = cnt_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam cnt_t VLast   = cnt_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam cnt_t HAct    = cnt_t'(H_ACTIVE);
  localparam cnt_t VAct    = cnt_t'(V_ACTIVE);
  localparam cnt_t HsFirst = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t HsLast  = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam cnt_t VsFirst = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t VsLast  = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);

  cnt_t  col_q, col_d, row_q, row_d;
  logic  hnot_q, hnot_d, vnot_q, vnot_d;
  logic  fs_q, fs_d;
  logic  col_wrap, row_wrap;
  sync_t sync_raw, sync_dly;

  always_comb begin
    col_wrap = (col_q == HLast);
    row_wrap = (row_q == VLast);
    col_d    = col_wrap ? '0 : col_q + cnt_t'(1);
    row_d    = row_q;
    if (col_wrap) begin
      row_d = row_wrap ? '0 : row_q + cnt_t'(1);
    end
    // Flags follow the next count so they flip on the same edge as col/row.
    hnot_d = (col_d >= HAct);
    vnot_d = (row_d >= VAct);
    // Only a real wrap to (0,0) marks a frame; the post-reset (0,0) never does.
    fs_d   = pix_en && col_wrap && row_wrap;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      col_q  <= '0;
      row_q  <= '0;
      hnot_q <= 1'b0;
      vnot_q <= 1'b0;
    end else if (pix_en) begin
      col_q  <= col_d;
      row_q  <= row_d;
      hnot_q <= hnot_d;
      vnot_q <= vnot_d;
    end
  end

  // The frame pulse runs on every clock so it lasts exactly one cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fs_q <= 1'b0;
    end else begin
      fs_q <= fs_d;
    end
  end

  always_comb begin
    sync_raw.hsync = !in_window(col_q, HsFirst, HsLast);
    sync_raw.vsync = !in_window(row_q, VsFirst, VsLast);
  end

  sync_delay_line #(
    .Depth(SYNC_DELAY)
  ) u_sync_delay_line (
    .CLK     (CLK),
    .RST     (RST),
    .en      (pix_en),
    .sync_in (sync_raw),
    .sync_out(sync_dly)
  );

  assign col         = col_q;
  assign row         = row_q;
  assign hnotactive  = hnot_q;
  assign vnotactive  = vnot_q;
  assign hsync       = sync_dly.hsync;
  assign vsync       = sync_dly.vsync;
  assign frame_start = fs_q;

endmodule
